// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch packet layout used by fetch and dual-issue decode.
package cpu_pkg;
  localparam int INST_WIDTH     = 32;
  localparam int INST_PER_FETCH = 2;
  localparam int PKT_PC_WIDTH   = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PKT_PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0]     inst0;
    logic [INST_WIDTH-1:0]     inst1;
    logic [INST_PER_FETCH-1:0] mask;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch packets with flush; head is read combinationally.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  fetch_pkt_t wdata,
  output fetch_pkt_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  fetch_pkt_t    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC sequencing, ROM word split into dual-issue packets, redirect flush.
// Optional FETCH_BYPASS_EN lets the live packet reach out_* when the queue is empty.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    FQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [31:0]           out_inst0,
  output logic [31:0]           out_inst1,
  output logic [1:0]            out_mask
);
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-4:0] word_nxt;
  fetch_pkt_t          live, head, shown;
  logic                q_full, q_empty, q_push, q_pop;
  logic                bypass, handshake, advance;

  assign rom_addr = fetch_pc[ADDR_WIDTH+2:3];
  assign word_nxt = fetch_pc[PC_WIDTH-1:3] + {{(PC_WIDTH-4){1'b0}}, 1'b1};

  always_comb begin
    live.pc    = {fetch_pc[PC_WIDTH-1:3], 3'b000};
    live.inst0 = rom_rdata[31:0];
    live.inst1 = rom_rdata[63:32];
    live.mask  = fetch_pc[2] ? 2'b10 : 2'b11;
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = q_empty && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !srst && (!q_empty || bypass);
  assign shown     = bypass ? live : head;
  assign handshake = out_valid && out_ready;
  assign advance   = !redirect && (!q_full || handshake);
  // A bypassed packet that decode takes this cycle never enters the queue.
  assign q_push    = advance && !(bypass && out_ready);
  assign q_pop     = handshake && !q_empty;

  assign out_pc    = out_valid ? shown.pc    : '0;
  assign out_inst0 = out_valid ? shown.inst0 : '0;
  assign out_inst1 = out_valid ? shown.inst1 : '0;
  assign out_mask  = out_valid ? shown.mask  : '0;

  always_ff @(posedge clk) begin
    if (srst)          fetch_pc <= {RESET_PC[PC_WIDTH-1:3], 3'b000};
    else if (redirect) fetch_pc <= redirect_pc & {{(PC_WIDTH-2){1'b1}}, 2'b00};
    else if (advance)  fetch_pc <= {word_nxt, 3'b000};
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk   (clk),
    .srst  (srst),
    .flush (redirect),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (live),
    .head  (head),
    .full  (q_full),
    .empty (q_empty)
  );
endmodule
